// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush controller for the fetch -> decode -> execute pipeline.
// Handles load-use bubbles, taken-branch front-end flushes and
// multi-cycle vector-op freezes. All control state lives here.
// Optional build macro: HAZARD_PERF_CNT_EN adds the stall_cycles and
// flush_events performance counters.
module pipeline_hazard_ctrl #(
  parameter int REG_BITS            = 4,
  parameter int VCNT_BITS           = 4,
  parameter int BRANCH_FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_BITS-1:0]  id_rs1,
  input  logic [REG_BITS-1:0]  id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_BITS-1:0]  ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_branch_taken,
  input  logic                 vec_start,
  input  logic [VCNT_BITS-1:0] vec_len,
  output logic                 fetch_en,
  output logic                 decode_en,
  output logic                 decode_flush,
  output logic                 execute_flush,
  output logic                 busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_events
`endif
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] VSTALL = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;

  // The branch cycle itself is flushed in RUN, so FLUSH covers the rest.
  localparam logic [VCNT_BITS-1:0] FLUSH_RELOAD = VCNT_BITS'(BRANCH_FLUSH_CYCLES - 1);
  localparam logic [VCNT_BITS-1:0] CNT_ONE      = VCNT_BITS'(1);
  localparam bit                   MULTI_FLUSH  = (BRANCH_FLUSH_CYCLES > 1);

  logic [1:0]           state_q, state_d;
  logic [VCNT_BITS-1:0] cnt_q, cnt_d;
  logic                 lu;
  logic                 fetch_en_c, decode_en_c, decode_flush_c, execute_flush_c;

  // Register 0 is an ordinary register for hazard purposes.
  assign lu = ex_mem_read &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));

  // Next-state, counter and raw control outputs from state and hazard inputs.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    fetch_en_c      = 1'b1;
    decode_en_c     = 1'b1;
    decode_flush_c  = 1'b0;
    execute_flush_c = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          // Branch wins over any vector start or load-use in the same cycle.
          decode_flush_c  = 1'b1;
          execute_flush_c = 1'b1;
          if (MULTI_FLUSH) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (vec_start && (vec_len != '0)) begin
          // The start cycle is the first frozen cycle; VSTALL holds the
          // remaining vec_len-1, so a length of 1 never leaves RUN.
          fetch_en_c  = 1'b0;
          decode_en_c = 1'b0;
          if (vec_len != CNT_ONE) begin
            state_d = VSTALL;
            cnt_d   = vec_len - CNT_ONE;
          end
        end else if (lu) begin
          // One bubble: the load moves on next cycle and the hazard clears.
          fetch_en_c      = 1'b0;
          decode_en_c     = 1'b0;
          execute_flush_c = 1'b1;
        end
      end
      VSTALL: begin
        fetch_en_c  = 1'b0;
        decode_en_c = 1'b0;
        cnt_d       = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        decode_flush_c = 1'b1;
        if (ex_branch_taken) begin
          // A fresh branch restarts the whole flush window.
          execute_flush_c = 1'b1;
          cnt_d           = FLUSH_RELOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q <= CNT_ONE) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset overrides the outputs combinationally so they react without a clock.
  always_comb begin
    fetch_en      = fetch_en_c;
    decode_en     = decode_en_c;
    decode_flush  = decode_flush_c;
    execute_flush = execute_flush_c;
    busy          = (state_q != RUN);
    if (!reset) begin
      fetch_en      = 1'b0;
      decode_en     = 1'b0;
      decode_flush  = 1'b1;
      execute_flush = 1'b1;
      busy          = 1'b0;
    end
  end

  // FSM state and shared down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_events_q;
  logic        branch_accepted;

  // Branches are only ignored while the front end is frozen.
  assign branch_accepted = ex_branch_taken && (state_q != VSTALL);

  // Free-running, wrapping performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (!fetch_en) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (branch_accepted) begin
        flush_events_q <= flush_events_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: fixed vector table, hand-written
// reset/perf sequences and randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int BFC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_rs1, id_rs2, ex_rd, vec_len;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, vec_start;
  logic       fetch_en, decode_en, decode_flush, execute_flush, busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int errors = 0;
  int checks = 0;

  pipeline_hazard_ctrl #(
    .REG_BITS(4), .VCNT_BITS(4), .BRANCH_FLUSH_CYCLES(BFC)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .vec_start(vec_start), .vec_len(vec_len),
    .fetch_en(fetch_en), .decode_en(decode_en),
    .decode_flush(decode_flush), .execute_flush(execute_flush),
    .busy(busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: cycles left in a flush window / in a freeze.
  int m_flush_rem  = 0;
  int m_freeze_rem = 0;
  int m_nflush, m_nfreeze;
  logic m_fe, m_de, m_df, m_ef, m_bz;
  int unsigned m_stall = 0;
  int unsigned m_fevt  = 0;
  logic m_bracc;

  typedef struct {
    logic br, vs; logic [3:0] vl; logic mr; logic [3:0] rd, rs1, rs2; logic u1, u2;
    logic fe, de, df, ef, bz;
  } vec_t;

  vec_t tab[28];

  function automatic vec_t mk(input logic br, vs, input logic [3:0] vl, input logic mr,
                              input logic [3:0] rd, rs1, rs2, input logic u1, u2,
                              input logic fe, de, df, ef, bz);
    vec_t v;
    v.br = br; v.vs = vs; v.vl = vl; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.u1 = u1; v.u2 = u2; v.fe = fe; v.de = de; v.df = df; v.ef = ef; v.bz = bz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic br, vs, input logic [3:0] vl, input logic mr,
                       input logic [3:0] rd, rs1, rs2, input logic u1, u2);
    ex_branch_taken = br; vec_start = vs; vec_len = vl; ex_mem_read = mr;
    ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
  endtask

  // Outputs and next model state for the currently driven inputs.
  task automatic model_eval();
    logic lu;
    lu = ex_mem_read && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    m_nflush = m_flush_rem; m_nfreeze = m_freeze_rem;
    m_fe = 1; m_de = 1; m_df = 0; m_ef = 0; m_bz = 0; m_bracc = 0;
    if (m_flush_rem > 0) begin
      m_df = 1; m_bz = 1; m_ef = ex_branch_taken; m_bracc = ex_branch_taken;
      m_nflush = ex_branch_taken ? BFC - 1 : m_flush_rem - 1;
    end else if (m_freeze_rem > 0) begin
      m_fe = 0; m_de = 0; m_bz = 1;
      m_nfreeze = m_freeze_rem - 1;
    end else if (ex_branch_taken) begin
      m_df = 1; m_ef = 1; m_bracc = 1;
      m_nflush = BFC - 1;
    end else if (vec_start && vec_len != 0) begin
      m_fe = 0; m_de = 0;
      m_nfreeze = int'(vec_len) - 1;
    end else if (lu) begin
      m_fe = 0; m_de = 0; m_ef = 1;
    end
  endtask

  task automatic model_commit();
    m_flush_rem = m_nflush; m_freeze_rem = m_nfreeze;
    if (!m_fe) m_stall++;
    if (m_bracc) m_fevt++;
  endtask

  task automatic model_reset();
    m_flush_rem = 0; m_freeze_rem = 0; m_stall = 0; m_fevt = 0;
  endtask

  // One clock of stimulus checked against the model (called at posedge+1).
  task automatic step(input string name, input logic br, vs, input logic [3:0] vl,
                      input logic mr, input logic [3:0] rd, rs1, rs2, input logic u1, u2);
    drive(br, vs, vl, mr, rd, rs1, rs2, u1, u2);
    model_eval();
    @(negedge clk);
    chk({name, ".fetch_en"}, fetch_en, m_fe);
    chk({name, ".decode_en"}, decode_en, m_de);
    chk({name, ".decode_flush"}, decode_flush, m_df);
    chk({name, ".execute_flush"}, execute_flush, m_ef);
    chk({name, ".busy"}, busy, m_bz);
`ifdef HAZARD_PERF_CNT_EN
    chk({name, ".stall_cycles"}, stall_cycles, m_stall);
    chk({name, ".flush_events"}, flush_events, m_fevt);
`endif
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, ".fetch_en"}, fetch_en, 1'b0);
    chk({name, ".decode_en"}, decode_en, 1'b0);
    chk({name, ".decode_flush"}, decode_flush, 1'b1);
    chk({name, ".execute_flush"}, execute_flush, 1'b1);
    chk({name, ".busy"}, busy, 1'b0);
  endtask

  initial begin
    //          br vs vl  mr rd rs1 rs2 u1 u2   fe de df ef bz
    tab[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    tab[1]  = mk(0, 0, 0, 1, 5, 0, 5, 0, 1,   0, 0, 0, 1, 0);
    tab[2]  = mk(0, 0, 0, 0, 5, 0, 5, 0, 1,   1, 1, 0, 0, 0);
    tab[3]  = mk(0, 0, 0, 1, 5, 3, 5, 1, 0,   1, 1, 0, 0, 0);
    tab[4]  = mk(0, 0, 0, 1, 0, 0, 7, 1, 0,   0, 0, 0, 1, 0);
    tab[5]  = mk(0, 1, 3, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    tab[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
    tab[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
    tab[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    tab[9]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    tab[10] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 1, 0);
    tab[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 1);
    tab[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    tab[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 1, 0);
    tab[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 1, 1);
    tab[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 1);
    tab[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    tab[17] = mk(1, 1, 4, 1, 5, 5, 0, 1, 0,   1, 1, 1, 1, 0);
    tab[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 1);
    tab[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    tab[20] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    tab[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    tab[22] = mk(0, 1, 2, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    tab[23] = mk(1, 0, 0, 1, 5, 5, 0, 1, 0,   0, 0, 0, 0, 1);
    tab[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    tab[25] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 1, 0);
    tab[26] = mk(0, 1, 3, 1, 5, 5, 0, 1, 0,   1, 1, 1, 0, 1);
    tab[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);

    // Reset held low for three cycles.
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_reset_outs("in_reset");
`ifdef HAZARD_PERF_CNT_EN
      chk("in_reset.stall_cycles", stall_cycles, 32'd0);
`endif
    end
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();

    // Fixed vectors, starting in the first cycle after release.
    for (int i = 0; i < 28; i++) begin
      drive(tab[i].br, tab[i].vs, tab[i].vl, tab[i].mr, tab[i].rd,
            tab[i].rs1, tab[i].rs2, tab[i].u1, tab[i].u2);
      model_eval();
      @(negedge clk);
      chk($sformatf("tab%0d.fetch_en", i), fetch_en, tab[i].fe);
      chk($sformatf("tab%0d.decode_en", i), decode_en, tab[i].de);
      chk($sformatf("tab%0d.decode_flush", i), decode_flush, tab[i].df);
      chk($sformatf("tab%0d.execute_flush", i), execute_flush, tab[i].ef);
      chk($sformatf("tab%0d.busy", i), busy, tab[i].bz);
      @(posedge clk);
      model_commit();
      #1;
    end

    // Reset pulled low asynchronously in the 2nd cycle of a vec_len=5 stall.
    step("vst5_start", 0, 1, 5, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("vst5_c2.busy_before_reset", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk_reset_outs("async_reset");
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_reset.fetch_en", fetch_en, 1'b1);
    chk("post_reset.decode_en", decode_en, 1'b1);
    chk("post_reset.busy", busy, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    chk("post_reset.stall_cycles", stall_cycles, 32'd0);
`endif
    @(posedge clk); #1;

    // Uninterrupted vec_len=5 stall: exactly five frozen cycles.
    step("vst5b_start", 0, 1, 5, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("vst5b_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("vst5b_done.fetch_en", fetch_en, 1'b1);
    chk("vst5b_done.busy", busy, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    chk("vst5b_done.stall_cycles", stall_cycles, 32'd5);
`endif
    @(posedge clk); #1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic br, vs, mr, u1, u2;
      logic [3:0] vl, rd, rs1, rs2;
      br  = ($urandom_range(7) == 0);
      vs  = ($urandom_range(5) == 0);
      vl  = 4'($urandom_range(15));
      mr  = 1'($urandom_range(1));
      rd  = 4'($urandom_range(3));
      rs1 = 4'($urandom_range(3));
      rs2 = 4'($urandom_range(3));
      u1  = 1'($urandom_range(1));
      u2  = 1'($urandom_range(1));
      step("rand", br, vs, vl, mr, rd, rs1, rs2, u1, u2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
